// File: rtl/fb_rotate_arbiter.sv
// fb_rotate_arbiter: shares one single-port frame-buffer RAM between a buffered
// pixel-write stream and the rotated scan-out read stream. Reads win by default;
// after STARVE_MAX reads with writes pending, a write slot is forced.
// Optional statistics counters are enabled with the FB_ARB_STATS_EN macro.
module fb_rotate_arbiter #(
    parameter int unsigned AW         = 17,
    parameter int unsigned DW         = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          wr_drop,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]   stat_force,
    output logic [15:0]   stat_drop
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_t;

    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic [1:0]    rd_pipe;

    logic   empty;
    logic   full;
    logic   force_wr;
    logic   push;
    logic   pop;
    grant_t grant;

    // Grant selection and FIFO handshake, decided from the current state
    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(FIFO_DEPTH));
        force_wr = !empty && (starve_cnt == SW'(STARVE_MAX));
        grant    = GNT_IDLE;
        if (force_wr) begin
            grant = GNT_WRITE;
        end else if (rd_req) begin
            grant = GNT_READ;
        end else if (!empty) begin
            grant = GNT_WRITE;
        end
        push     = wr_valid && !full;
        pop      = (grant == GNT_WRITE);
        wr_ready = !full;
        rd_ready = !force_wr;
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[tail] <= wr_addr;
            fifo_data[tail] <= wr_data;
        end
    end

    // FIFO pointers, starvation guard, RAM port and read-return pipeline
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            starve_cnt <= '0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_din    <= '0;
            rd_pipe    <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            wr_drop    <= 1'b0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end

            if (pop || empty) begin
                starve_cnt <= '0;
            end else if ((grant == GNT_READ) && (starve_cnt != SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            case (grant)
                GNT_WRITE: begin
                    ram_we   <= 1'b1;
                    ram_addr <= fifo_addr[head];
                    ram_din  <= fifo_data[head];
                end
                GNT_READ: begin
                    ram_we   <= 1'b0;
                    ram_addr <= rd_addr;
                end
                default: ram_we <= 1'b0;
            endcase

            // Stage 0: address issued; stage 1: RAM sampled; then data captured
            rd_pipe  <= {rd_pipe[0], (grant == GNT_READ)};
            rd_valid <= rd_pipe[1];
            if (rd_pipe[1]) rd_data <= ram_dout;

            if (wr_valid && full) wr_drop <= 1'b1;
        end
    end

`ifdef FB_ARB_STATS_EN
    // Saturating counts of forced write slots and discarded writes
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            stat_force <= '0;
            stat_drop  <= '0;
        end else begin
            if (force_wr && (stat_force != 16'hFFFF)) stat_force <= stat_force + 16'(1);
            if (wr_valid && full && (stat_drop != 16'hFFFF)) stat_drop <= stat_drop + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fb_rotate_arbiter.sv
// Testbench for fb_rotate_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against a transaction-level model (queue + memory image).
// Build with FB_ARB_STATS_EN defined to also check the statistics counters.
module tb_fb_rotate_arbiter;

    localparam int unsigned AW         = 17;
    localparam int unsigned DW         = 8;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned STARVE_MAX = 4;

    logic          clk_sys;
    logic          reset;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_drop;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef FB_ARB_STATS_EN
    logic [15:0]   stat_force;
    logic [15:0]   stat_drop;
`endif

    fb_rotate_arbiter #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_drop(wr_drop),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef FB_ARB_STATS_EN
        , .stat_force(stat_force), .stat_drop(stat_drop)
`endif
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM seen by the DUT
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // Reference model state: pending write queue and expected RAM image
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_starve;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic          m_rdv;
    logic [DW-1:0] m_rdd;
    logic          p1v, p2v;
    logic [DW-1:0] p1d, p2d;
    logic          m_drop;
    int            m_force_cnt;
    int            m_drop_cnt;
    int            rdy_low;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_starve    = 0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_din       = '0;
        m_rdv       = 1'b0;
        m_rdd       = '0;
        p1v         = 1'b0;
        p2v         = 1'b0;
        p1d         = '0;
        p2d         = '0;
        m_drop      = 1'b0;
        m_force_cnt = 0;
        m_drop_cnt  = 0;
    endtask

    task automatic check_regs();
        check_eq("ram_we", 32'(ram_we), 32'(m_we));
        check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
        check_eq("ram_din", 32'(ram_din), 32'(m_din));
        check_eq("rd_valid", 32'(rd_valid), 32'(m_rdv));
        if (m_rdv) check_eq("rd_data", 32'(rd_data), 32'(m_rdd));
        check_eq("wr_drop", 32'(wr_drop), 32'(m_drop));
`ifdef FB_ARB_STATS_EN
        check_eq("stat_force", 32'(stat_force), 32'(m_force_cnt));
        check_eq("stat_drop", 32'(stat_drop), 32'(m_drop_cnt));
`endif
    endtask

    // Assert reset at a falling edge, check cleared outputs, release two cycles later
    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        model_clear();
        #1;
        check_regs();
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_rd_ready", 32'(rd_ready), 32'd1);
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, predict the rising edge, check after it
    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic rq, input logic [AW-1:0] ra);
        bit   emp, ful, frc;
        ent_t e;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_req   = rq;
        rd_addr  = ra;
        #1;
        // A write issued last cycle lands in RAM at the coming edge
        if (m_we) ref_mem[m_addr] = m_din;
        emp = (q.size() == 0);
        ful = (q.size() == DEPTH);
        frc = !emp && (m_starve == STARVE_MAX);
        check_eq("wr_ready", 32'(wr_ready), 32'(!ful));
        check_eq("rd_ready", 32'(rd_ready), 32'(!frc));
        if (!rd_ready) rdy_low++;

        m_rdv = p2v;
        if (p2v) m_rdd = p2d;
        p2v = p1v;
        p2d = p1d;
        p1v = 1'b0;
        if (frc || (!rq && !emp)) begin
            e        = q.pop_front();
            m_we     = 1'b1;
            m_addr   = e.a;
            m_din    = e.d;
            m_starve = 0;
            if (frc && m_force_cnt < 65535) m_force_cnt++;
        end else if (rq) begin
            m_we  = 1'b0;
            m_addr = ra;
            p1v   = 1'b1;
            p1d   = ref_mem[ra];
            if (emp) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
        end else begin
            m_we     = 1'b0;
            m_starve = 0;
        end
        if (wv && !ful) begin
            e.a = wa;
            e.d = wd;
            q.push_back(e);
        end else if (wv) begin
            m_drop = 1'b1;
            if (m_drop_cnt < 65535) m_drop_cnt++;
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            pw, pr;
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        rdy_low  = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        @(negedge clk_sys);
        do_reset();

        // Idle after reset
        idle(10);

        // Single write then read-back of the same address
        step(1'b1, 17'h00123, 8'hA5, 1'b0, '0);
        idle(2);
        step(1'b0, '0, '0, 1'b1, 17'h00123);
        idle(4);
        check_eq("readback_mem", 32'(mem[17'h00123]), 32'h A5);

        // Continuous reads with one queued write: exactly one forced slot
        rdy_low = 0;
        step(1'b1, 17'h00200, 8'h3C, 1'b1, 17'h00123);
        for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b1, AW'(17'h00120 + i));
        check_eq("force_slots", 32'(rdy_low), 32'd1);
        idle(4);

        // Fill the FIFO under saturating reads until writes are dropped
        for (int i = 0; i < 12; i++) step(1'b1, AW'(17'h00300 + i), 8'(8'h10 + i), 1'b1, 17'h00200);
        check_eq("drop_seen", 32'(wr_drop), 32'd1);
        idle(DEPTH * 2);

        // Build count=3, then push and pop in the same cycle
        for (int i = 0; i < 3; i++) step(1'b1, AW'(17'h00400 + i), 8'(8'h40 + i), 1'b1, 17'h00300);
        step(1'b1, 17'h00403, 8'h43, 1'b0, '0);
        check_eq("pushpop_count", 32'(q.size()), 32'd3);
        idle(6);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, AW'(17'h00400 + i));
        idle(4);

        // Reset with writes queued and reads in flight
        for (int i = 0; i < 7; i++) step(1'b1, AW'(17'h00500 + i), 8'(8'h50 + i), 1'b1, 17'h00400);
        @(negedge clk_sys);
        m_rdv = 1'b0;
        do_reset();
        check_eq("rst_q_empty", 32'(wr_ready), 32'd1);
        idle(6);
        check_eq("rst_no_write", 32'(mem[17'h00506]), 32'd0);

        // Randomized traffic with changing write/read densities and rare resets
        for (int blk = 0; blk < 6; blk++) begin
            pw = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 500; i++) begin
                a = AW'($urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? 17'h1FF00 : 17'h0);
                if ($urandom_range(0, 399) == 0) begin
                    do_reset();
                end else begin
                    step(($urandom_range(0, 99) < pw), a, DW'($urandom),
                         ($urandom_range(0, 99) < pr), AW'($urandom_range(0, 31)));
                end
            end
        end
        idle(DEPTH * (STARVE_MAX + 1) + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
